// File: rtl/oam_dma_ctrl_if.sv
// Byte-wide memory bus: the master drives the request, the slave returns read data and stall.
interface oam_dma_ctrl_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic        re;
  logic [7:0]  rdata;
  logic        stall;

  modport master (output addr, wdata, we, re, input rdata);
  modport slave  (input addr, wdata, we, re, output rdata, stall);
endinterface

// File: rtl/oam_dma_ctrl.sv
// Bus owner between CPU and memory: passes CPU accesses through when idle and runs
// the OAM DMA page copy triggered by a write to the DMA source-page register.
//
// state | meaning
// IDLE  | CPU owns the bus (pass-through)
// DELAY | start-up gap after a register write, bus idle
// READ  | DMA reads source byte {src_hi,00}+idx
// WRITE | DMA writes that byte to DST_BASE+idx
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] DST_BASE     = 16'hFE00,
  parameter int          LENGTH       = 160,
  parameter int          START_DELAY  = 1
) (
  input  logic           clock,
  input  logic           reset,
  oam_dma_ctrl_if.slave  cpu,
  oam_dma_ctrl_if.master mem,
  output logic           dma_active,
  output logic           dma_done
);

  localparam int         DCW        = 16;
  localparam logic [7:0] LAST_IDX   = 8'(LENGTH - 1);
  localparam logic [DCW-1:0] DELAY_LOAD = DCW'(START_DELAY - 1);

  typedef enum logic [1:0] {IDLE, DELAY, READ, WRITE} state_t;

  state_t         state_q, state_d;
  logic [7:0]     idx_q, idx_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [7:0]     src_hi_q, src_hi_d;
  logic           rd_reg_q;
  logic           done_q, done_d;

  logic        is_reg, reg_wr, reg_rd;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we, bus_re;

  assign is_reg = (cpu.addr == DMA_REG_ADDR);
  assign reg_wr = cpu.we & is_reg;
  assign reg_rd = cpu.re & is_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= 8'h00;
      dcnt_q   <= '0;
      src_hi_q <= 8'h00;
      rd_reg_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dcnt_q   <= dcnt_d;
      src_hi_q <= src_hi_d;
      rd_reg_q <= reg_rd;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dcnt_d   = dcnt_q;
    src_hi_d = src_hi_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: ;
      DELAY: begin
        if (dcnt_q == '0) state_d = READ;
        else              dcnt_d  = dcnt_q - 1'b1;
      end
      READ: state_d = WRITE;
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
    // A register write restarts the copy from any state and suppresses a pending done.
    if (reg_wr) begin
      src_hi_d = cpu.wdata;
      idx_d    = 8'h00;
      dcnt_d   = DELAY_LOAD;
      state_d  = DELAY;
      done_d   = 1'b0;
    end
  end

  always_comb begin
    bus_addr  = 16'h0000;
    bus_wdata = 8'h00;
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    case (state_q)
      IDLE: begin
        bus_addr  = cpu.addr;
        bus_wdata = cpu.wdata;
        bus_we    = cpu.we & ~is_reg;
        bus_re    = cpu.re & ~is_reg;
      end
      READ: begin
        bus_addr = {src_hi_q, 8'h00} + {8'h00, idx_q};
        bus_re   = 1'b1;
      end
      WRITE: begin
        bus_addr  = DST_BASE + {8'h00, idx_q};
        bus_wdata = mem.rdata;
        bus_we    = 1'b1;
      end
      default: ;
    endcase
    // Strobes are held off while reset is asserted so an aborted copy touches nothing.
    if (!reset) begin
      bus_we = 1'b0;
      bus_re = 1'b0;
    end
  end

  assign mem.addr  = bus_addr;
  assign mem.wdata = bus_wdata;
  assign mem.we    = bus_we;
  assign mem.re    = bus_re;

  assign dma_active = (state_q != IDLE);
  assign dma_done   = done_q;
  assign cpu.stall  = reset & dma_active & (cpu.we | cpu.re) & ~is_reg;
  assign cpu.rdata  = rd_reg_q ? src_hi_q : mem.rdata;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl with a byte-wide synchronous memory model.
module tb_oam_dma_ctrl;
  logic clock = 1'b0;
  logic reset;
  logic dma_active, dma_done;
  int   errors = 0;
  int   checks = 0;
  int   act_cnt = 0;
  int   done_cnt = 0;

  oam_dma_ctrl_if cpu_bus ();
  oam_dma_ctrl_if mem_bus ();
  assign mem_bus.stall = 1'b0;

  oam_dma_ctrl dut (
    .clock(clock), .reset(reset), .cpu(cpu_bus), .mem(mem_bus),
    .dma_active(dma_active), .dma_done(dma_done)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] pat(input logic [15:0] a);
    if (a == 16'h0100) return 8'h3E;
    if (a == 16'h8000) return 8'h77;
    case (a[15:8])
      8'hC0:   return a[7:0] ^ 8'h5A;
      8'hB0:   return a[7:0] + 8'd1;
      8'hD0:   return a[7:0] ^ 8'hA5;
      8'hFE:   return 8'h11;
      default: return a[7:0] ^ a[15:8];
    endcase
  endfunction

  logic [7:0] mem [0:65535];
  bit mem_init;
  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i));
      mem_init <= 1'b1;
    end else begin
      if (mem_bus.we) mem[mem_bus.addr] <= mem_bus.wdata;
      if (mem_bus.re) mem_bus.rdata <= mem[mem_bus.addr];
    end
  end

  always @(posedge clock) begin
    if (dma_active) act_cnt <= act_cnt + 1;
    if (dma_done)   done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_dst(input string tag, input int lo, input int hi, input logic [7:0] page);
    int bad = 0;
    for (int i = lo; i < hi; i++)
      if (mem[16'hFE00 + 16'(i)] !== pat({page, 8'(i)})) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (dma_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic reg_write(input logic [7:0] v);
    cpu_bus.addr = 16'hFF46; cpu_bus.wdata = v; cpu_bus.we = 1'b1;
    #1;
    chk("regwr_stall", cpu_bus.stall, 0);
    tick();
    cpu_bus.we = 1'b0;
  endtask

  initial begin
    bit seen;
    int a0, d0, n;
    reset = 1'b0;
    cpu_bus.addr = 16'h0100; cpu_bus.wdata = 8'h00; cpu_bus.we = 1'b0; cpu_bus.re = 1'b1;
    tick(); tick();
    chk("rst_mem_re", mem_bus.re, 0);
    chk("rst_stall", cpu_bus.stall, 0);
    chk("rst_active", dma_active, 0);
    chk("rst_done", dma_done, 0);
    cpu_bus.re = 1'b0; reset = 1'b1;
    tick();

    // idle pass-through read
    cpu_bus.addr = 16'h0100; cpu_bus.re = 1'b1; #1;
    chk("t1_mem_re", mem_bus.re, 1);
    chk("t1_mem_addr", mem_bus.addr, 16'h0100);
    chk("t1_stall", cpu_bus.stall, 0);
    tick(); cpu_bus.re = 1'b0; #1;
    chk("t1_rdata", cpu_bus.rdata, 8'h3E);

    // full transfer from C000
    cpu_bus.addr = 16'hFF46; cpu_bus.wdata = 8'hC0; cpu_bus.we = 1'b1; #1;
    chk("t2_wr_mem_we", mem_bus.we, 0);
    chk("t2_wr_mem_re", mem_bus.re, 0);
    tick(); cpu_bus.we = 1'b0; a0 = act_cnt; d0 = done_cnt; #1;
    chk("t2_delay_active", dma_active, 1);
    chk("t2_delay_re", mem_bus.re, 0);
    chk("t2_delay_we", mem_bus.we, 0);
    tick();
    chk("t2_read_re", mem_bus.re, 1);
    chk("t2_read_addr", mem_bus.addr, 16'hC000);
    tick();
    chk("t2_write_we", mem_bus.we, 1);
    chk("t2_write_addr", mem_bus.addr, 16'hFE00);
    chk("t2_write_data", mem_bus.wdata, 8'h5A);
    wait_done(seen);
    chk("t2_done_seen", seen, 1);
    chk("t2_active_fall", dma_active, 0);
    chk("t2_active_cycles", act_cnt - a0, 321);
    tick();
    chk("t2_done_pulse", dma_done, 0);
    chk("t2_done_count", done_cnt - d0, 1);
    chk_dst("t2_dst", 0, 160, 8'hC0);
    chk("t2_beyond", mem[16'hFEA0], 8'h11);

    // CPU read stalled from idx 10 until the first idle cycle
    reg_write(8'hB0);
    repeat (21) tick();
    cpu_bus.addr = 16'h8000; cpu_bus.re = 1'b1; #1;
    chk("t3_stall", cpu_bus.stall, 1);
    chk("t3_dma_addr", mem_bus.addr, 16'hB00A);
    n = 0;
    while (cpu_bus.stall && n < 400) begin
      tick();
      n++;
    end
    chk("t3_stall_released", cpu_bus.stall, 0);
    chk("t3_stall_len", n, 300);
    chk("t3_done", dma_done, 1);
    chk("t3_issue_re", mem_bus.re, 1);
    chk("t3_issue_addr", mem_bus.addr, 16'h8000);
    tick(); cpu_bus.re = 1'b0; #1;
    chk("t3_rdata", cpu_bus.rdata, 8'h77);
    chk_dst("t3_dst", 0, 160, 8'hB0);

    // register read mid-DMA, then restart from D000 at idx 50
    reg_write(8'hC0);
    repeat (42) tick();
    cpu_bus.addr = 16'hFF46; cpu_bus.re = 1'b1; #1;
    chk("t4_stall", cpu_bus.stall, 0);
    chk("t4_mem_re", mem_bus.re, 0);
    chk("t4_dma_we", mem_bus.we, 1);
    chk("t4_dma_addr", mem_bus.addr, 16'hFE14);
    tick(); cpu_bus.re = 1'b0; #1;
    chk("t4_rdata", cpu_bus.rdata, 8'hC0);
    repeat (58) tick();
    chk("t5_idx50_addr", mem_bus.addr, 16'hC032);
    reg_write(8'hD0);
    a0 = act_cnt; d0 = done_cnt; #1;
    chk("t5_restart_re", mem_bus.re, 0);
    chk("t5_restart_active", dma_active, 1);
    tick();
    chk("t5_read_addr", mem_bus.addr, 16'hD000);
    wait_done(seen);
    chk("t5_done_seen", seen, 1);
    chk("t5_active_cycles", act_cnt - a0, 321);
    tick();
    chk("t5_done_count", done_cnt - d0, 1);
    chk_dst("t5_dst", 0, 160, 8'hD0);

    // reset pulse at idx 80
    reg_write(8'hC0);
    repeat (161) tick();
    d0 = done_cnt;
    reset = 1'b0; #1;
    chk("t6_rst_re", mem_bus.re, 0);
    chk("t6_rst_we", mem_bus.we, 0);
    tick(); reset = 1'b1; #1;
    chk("t6_active", dma_active, 0);
    chk("t6_done", dma_done, 0);
    chk("t6_mem_re", mem_bus.re, 0);
    chk("t6_mem_we", mem_bus.we, 0);
    repeat (5) tick();
    chk("t6_no_done", done_cnt - d0, 0);
    chk_dst("t6_dst_lo", 0, 80, 8'hC0);
    chk_dst("t6_dst_hi", 80, 160, 8'hD0);
    cpu_bus.addr = 16'hFF46; cpu_bus.re = 1'b1;
    tick(); cpu_bus.re = 1'b0; #1;
    chk("t6_src_hi", cpu_bus.rdata, 8'h00);

    // register write during the final WRITE restarts without done
    reg_write(8'hB0);
    repeat (320) tick();
    chk("t7_last_we", mem_bus.we, 1);
    chk("t7_last_addr", mem_bus.addr, 16'hFE9F);
    d0 = done_cnt;
    reg_write(8'hC0);
    #1;
    chk("t7_no_done", dma_done, 0);
    chk("t7_active", dma_active, 1);
    wait_done(seen);
    chk("t7_done_seen", seen, 1);
    tick();
    chk("t7_done_count", done_cnt - d0, 1);
    chk_dst("t7_dst", 0, 160, 8'hC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
